// File: rtl/sa_cache_pkg.sv
// Shared constants, FSM encoding and address helpers for the sa_cache miss controller.
package sa_cache_pkg;
  localparam int TAG_W    = 18;
  localparam int INDEX_W  = 8;
  localparam int OFFSET_W = 6;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_WB      = 3'd2,
    ST_FILL    = 3'd3,
    ST_INSTALL = 3'd4
  } state_e;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction
endpackage

// File: rtl/sa_timeout_cnt.sv
// Memory-ack watchdog: cleared outside a wait, counts waiting cycles, flags the last allowed one.
module sa_timeout_cnt #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count: saturates at the expiry value so it never wraps
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == LAST);
endmodule

// File: rtl/sa_cache_miss_ctrl.sv
// Sequences one CPU access through sa_cache: lookup, optional dirty writeback,
// line fill, install and replay, with a watchdog on every memory handshake.
module sa_cache_miss_ctrl
  import sa_cache_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_cpu_req,
  input  logic                i_cpu_we,
  input  logic [ADDR_W-1:0]   i_cpu_addr,
  input  logic [DATA_W-1:0]   i_cpu_wdata,
  output logic                o_cpu_ready,
  output logic [DATA_W-1:0]   o_cpu_rdata,
  output logic                o_error,
  output logic [TAG_W-1:0]    o_tag,
  output logic [INDEX_W-1:0]  o_index,
  output logic [OFFSET_W-1:0] o_offset,
  output logic [DATA_W-1:0]   o_dataW,
  output logic                o_memRW,
  input  logic [DATA_W-1:0]   i_cache_data,
  input  logic                i_cache_miss,
  input  logic                i_evict,
  input  logic [ADDR_W-1:0]   i_evict_addr,
  input  logic [DATA_W-1:0]   i_evict_data,
  output logic [DATA_W-1:0]   o_memory_line,
  output logic                o_memory_response,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic                i_mem_ack,
  input  logic [DATA_W-1:0]   i_mem_rdata
);
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                replay_q, replay_d;
  logic                error_q, error_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                memrw_q, memrw_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                resp_q, resp_d;
  logic [DATA_W-1:0]   mline_q, mline_d;
  logic                busy_s;
  logic                expire_s;

  assign busy_s = (state_q == ST_WB) || (state_q == ST_FILL);

  sa_timeout_cnt #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (!busy_s || i_mem_ack),
    .en_i     (busy_s && !i_mem_ack),
    .expire_o (expire_s)
  );

  // next state and next registered outputs; outputs default to idle values each cycle
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    replay_d    = replay_q;
    error_d     = error_q;
    ready_d     = 1'b0;
    rdata_d     = '0;
    memrw_d     = 1'b0;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    resp_d      = 1'b0;
    mline_d     = '0;
    case (state_q)
      ST_IDLE: begin
        // a held request is not re-accepted during its own completion pulse
        if (i_cpu_req && !ready_q) begin
          addr_d  = i_cpu_addr;
          we_d    = i_cpu_we;
          wdata_d = i_cpu_wdata;
          memrw_d = i_cpu_we;
          state_d = ST_LOOKUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        if (!i_cache_miss) begin
          ready_d = 1'b1;
          rdata_d = we_q ? '0 : i_cache_data;
          state_d = ST_IDLE;
        end else if (replay_q) begin
          error_d = 1'b1;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else if (i_evict) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = line_align(i_evict_addr);
          mem_wdata_d = i_evict_data;
          state_d     = ST_WB;
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = line_align(addr_q);
          state_d    = ST_FILL;
        end
      end
      ST_WB: begin
        if (i_mem_ack) begin
          mem_req_d  = 1'b1;
          mem_addr_d = line_align(addr_q);
          state_d    = ST_FILL;
        end else if (expire_s) begin
          error_d = 1'b1;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = mem_addr_q;
          mem_wdata_d = mem_wdata_q;
        end
      end
      ST_FILL: begin
        if (i_mem_ack) begin
          resp_d  = 1'b1;
          mline_d = i_mem_rdata;
          state_d = ST_INSTALL;
        end else if (expire_s) begin
          error_d = 1'b1;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = mem_addr_q;
        end
      end
      ST_INSTALL: begin
        replay_d = 1'b1;
        memrw_d  = we_q;
        state_d  = ST_LOOKUP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (state_d == ST_IDLE) replay_d = 1'b0;
    else                    replay_d = replay_d;
  end

  // state, latched request and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      replay_q    <= 1'b0;
      error_q     <= 1'b0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      memrw_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      resp_q      <= 1'b0;
      mline_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      replay_q    <= replay_d;
      error_q     <= error_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      memrw_q     <= memrw_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      resp_q      <= resp_d;
      mline_q     <= mline_d;
    end
  end

  assign o_tag             = addr_q[ADDR_W-1 -: TAG_W];
  assign o_index           = addr_q[OFFSET_W +: INDEX_W];
  assign o_offset          = addr_q[OFFSET_W-1:0];
  assign o_dataW           = wdata_q;
  assign o_memRW           = memrw_q;
  assign o_cpu_ready       = ready_q;
  assign o_cpu_rdata       = rdata_q;
  assign o_error           = error_q;
  assign o_mem_req         = mem_req_q;
  assign o_mem_we          = mem_we_q;
  assign o_mem_addr        = mem_addr_q;
  assign o_mem_wdata       = mem_wdata_q;
  assign o_memory_response = resp_q;
  assign o_memory_line     = mline_q;
endmodule

// File: tb/tb_sa_cache_miss_ctrl.sv
// Directed bench for sa_cache_miss_ctrl; the cache and memory are driven by hand step by step.
module tb_sa_cache_miss_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_cpu_req, i_cpu_we;
  logic [31:0] i_cpu_addr, i_cpu_wdata;
  logic        o_cpu_ready;
  logic [31:0] o_cpu_rdata;
  logic        o_error;
  logic [17:0] o_tag;
  logic [7:0]  o_index;
  logic [5:0]  o_offset;
  logic [31:0] o_dataW;
  logic        o_memRW;
  logic [31:0] i_cache_data;
  logic        i_cache_miss, i_evict;
  logic [31:0] i_evict_addr, i_evict_data;
  logic [31:0] o_memory_line;
  logic        o_memory_response;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  int n_vec = 0;
  int n_err = 0;
  int req_cycles = 0;
  int resp_cycles = 0;
  int ready_cycles = 0;

  always #5 clk = ~clk;

  sa_cache_miss_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr), .i_cpu_wdata(i_cpu_wdata),
    .o_cpu_ready(o_cpu_ready), .o_cpu_rdata(o_cpu_rdata), .o_error(o_error),
    .o_tag(o_tag), .o_index(o_index), .o_offset(o_offset), .o_dataW(o_dataW), .o_memRW(o_memRW),
    .i_cache_data(i_cache_data), .i_cache_miss(i_cache_miss), .i_evict(i_evict),
    .i_evict_addr(i_evict_addr), .i_evict_data(i_evict_data),
    .o_memory_line(o_memory_line), .o_memory_response(o_memory_response),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
  );

  // mid-cycle activity counters
  always @(negedge clk) begin
    if (o_mem_req)         req_cycles   <= req_cycles + 1;
    if (o_memory_response) resp_cycles  <= resp_cycles + 1;
    if (o_cpu_ready)       ready_cycles <= ready_cycles + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed still running, expected finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int r0, q0, p0, n;
    rst = 1'b0;
    i_cpu_req = 1'b0; i_cpu_we = 1'b0; i_cpu_addr = 32'h0; i_cpu_wdata = 32'h0;
    i_cache_data = 32'h0; i_cache_miss = 1'b0; i_evict = 1'b0;
    i_evict_addr = 32'h0; i_evict_data = 32'h0; i_mem_ack = 1'b0; i_mem_rdata = 32'h0;
    tick(); tick();
    chk("rst_ready", 32'(o_cpu_ready), 32'h0);
    chk("rst_memreq", 32'(o_mem_req), 32'h0);
    chk("rst_error", 32'(o_error), 32'h0);
    chk("rst_tag", 32'(o_tag), 32'h0);
    rst = 1'b1;

    // hit load, request held through the ready cycle
    r0 = ready_cycles; q0 = req_cycles;
    i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 32'h0000_0004;
    i_cache_miss = 1'b0; i_cache_data = 32'hDEAD_BEEF;
    tick();
    chk("hit_lookup_ready", 32'(o_cpu_ready), 32'h0);
    chk("hit_offset", 32'(o_offset), 32'h4);
    chk("hit_memrw", 32'(o_memRW), 32'h0);
    tick();
    chk("hit_ready", 32'(o_cpu_ready), 32'h1);
    chk("hit_rdata", o_cpu_rdata, 32'hDEAD_BEEF);
    tick();
    i_cpu_req = 1'b0;
    chk("hit_ready_single", 32'(o_cpu_ready), 32'h0);
    tick(); tick();
    chk("hit_ready_count", 32'(ready_cycles - r0), 32'h1);
    chk("hit_no_memreq", 32'(req_cycles - q0), 32'h0);

    // clean miss load, fill ack in the third wait cycle
    p0 = resp_cycles;
    i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 32'h0001_4008;
    i_cache_miss = 1'b1; i_evict = 1'b0;
    tick();
    tick();
    chk("cm_req", 32'(o_mem_req), 32'h1);
    chk("cm_we", 32'(o_mem_we), 32'h0);
    chk("cm_addr", o_mem_addr, 32'h0001_4000);
    chk("cm_tag", 32'(o_tag), 32'h5);
    chk("cm_index", 32'(o_index), 32'h0);
    tick();
    chk("cm_req_held", 32'(o_mem_req), 32'h1);
    tick();
    i_mem_ack = 1'b1; i_mem_rdata = 32'h1234_5678;
    i_cache_miss = 1'b0; i_cache_data = 32'h1234_5678;
    tick();
    i_mem_ack = 1'b0; i_mem_rdata = 32'h0;
    chk("cm_resp", 32'(o_memory_response), 32'h1);
    chk("cm_line", o_memory_line, 32'h1234_5678);
    chk("cm_req_drop", 32'(o_mem_req), 32'h0);
    tick();
    chk("cm_resp_pulse", 32'(o_memory_response), 32'h0);
    chk("cm_replay_ready", 32'(o_cpu_ready), 32'h0);
    tick();
    i_cpu_req = 1'b0;
    chk("cm_ready", 32'(o_cpu_ready), 32'h1);
    chk("cm_rdata", o_cpu_rdata, 32'h1234_5678);
    chk("cm_resp_count", 32'(resp_cycles - p0), 32'h1);
    chk("cm_error", 32'(o_error), 32'h0);
    tick();

    // dirty miss store: writeback, fill, install, replay
    i_cpu_req = 1'b1; i_cpu_we = 1'b1; i_cpu_addr = 32'h0006_0044; i_cpu_wdata = 32'h0BAD_F00D;
    i_cache_miss = 1'b1; i_evict = 1'b1;
    i_evict_addr = 32'h0002_0040; i_evict_data = 32'hAAAA_5555;
    tick();
    chk("dm_memrw_first", 32'(o_memRW), 32'h1);
    chk("dm_dataw", o_dataW, 32'h0BAD_F00D);
    tick();
    i_evict = 1'b0; i_evict_addr = 32'hFFFF_FFFF; i_evict_data = 32'hFFFF_FFFF;
    chk("dm_wb_req", 32'(o_mem_req), 32'h1);
    chk("dm_wb_we", 32'(o_mem_we), 32'h1);
    chk("dm_wb_addr", o_mem_addr, 32'h0002_0040);
    chk("dm_wb_wdata", o_mem_wdata, 32'hAAAA_5555);
    i_mem_ack = 1'b1;
    tick();
    chk("dm_fill_we", 32'(o_mem_we), 32'h0);
    chk("dm_fill_addr", o_mem_addr, 32'h0006_0040);
    chk("dm_fill_req", 32'(o_mem_req), 32'h1);
    i_mem_rdata = 32'h5555_0000; i_cache_miss = 1'b0;
    tick();
    i_mem_ack = 1'b0;
    chk("dm_resp", 32'(o_memory_response), 32'h1);
    chk("dm_line", o_memory_line, 32'h5555_0000);
    tick();
    chk("dm_memrw_replay", 32'(o_memRW), 32'h1);
    tick();
    i_cpu_req = 1'b0;
    chk("dm_ready", 32'(o_cpu_ready), 32'h1);
    chk("dm_rdata", o_cpu_rdata, 32'h0);
    tick();

    // timeout: no ack for the whole fill
    i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 32'h0000_1000;
    i_cache_miss = 1'b1; i_evict = 1'b0;
    q0 = req_cycles;
    tick(); tick();
    chk("to_req", 32'(o_mem_req), 32'h1);
    n = 0;
    while (!o_cpu_ready && n < 10) begin
      tick();
      n++;
    end
    i_cpu_req = 1'b0;
    chk("to_wait_cycles", 32'(n), 32'h4);
    chk("to_ready", 32'(o_cpu_ready), 32'h1);
    chk("to_rdata", o_cpu_rdata, 32'h0);
    chk("to_req_drop", 32'(o_mem_req), 32'h0);
    chk("to_req_cycles", 32'(req_cycles - q0), 32'h4);
    chk("to_error", 32'(o_error), 32'h1);
    tick();
    i_cpu_req = 1'b1; i_cpu_addr = 32'h0000_0008; i_cache_miss = 1'b0; i_cache_data = 32'h0000_00A5;
    tick(); tick();
    i_cpu_req = 1'b0;
    chk("to_hit_ready", 32'(o_cpu_ready), 32'h1);
    chk("to_hit_rdata", o_cpu_rdata, 32'h0000_00A5);
    chk("to_error_sticky", 32'(o_error), 32'h1);
    tick();

    // asynchronous reset in the middle of a fill
    i_cpu_req = 1'b1; i_cpu_addr = 32'h0000_3000; i_cache_miss = 1'b1;
    tick(); tick();
    chk("rf_req_before", 32'(o_mem_req), 32'h1);
    r0 = ready_cycles;
    #2 rst = 1'b0;
    #1;
    chk("rf_req_async", 32'(o_mem_req), 32'h0);
    chk("rf_error_clr", 32'(o_error), 32'h0);
    i_cpu_req = 1'b0;
    tick(); tick();
    chk("rf_no_ready", 32'(ready_cycles - r0), 32'h0);
    rst = 1'b1;
    tick();
    i_cpu_req = 1'b1; i_cpu_addr = 32'h0000_0010; i_cache_miss = 1'b0; i_cache_data = 32'hC0FF_EE00;
    tick(); tick();
    i_cpu_req = 1'b0;
    chk("rf_hit_ready", 32'(o_cpu_ready), 32'h1);
    chk("rf_hit_rdata", o_cpu_rdata, 32'hC0FF_EE00);
    tick();

    // double miss: replay misses again
    q0 = req_cycles; p0 = resp_cycles; r0 = ready_cycles;
    i_cpu_req = 1'b1; i_cpu_addr = 32'h0000_2000; i_cache_miss = 1'b1; i_evict = 1'b0;
    tick(); tick();
    i_mem_ack = 1'b1; i_mem_rdata = 32'h0F0F_0F0F;
    tick();
    i_mem_ack = 1'b0;
    tick(); tick();
    i_cpu_req = 1'b0;
    chk("dbl_ready", 32'(o_cpu_ready), 32'h1);
    chk("dbl_rdata", o_cpu_rdata, 32'h0);
    chk("dbl_error", 32'(o_error), 32'h1);
    tick(); tick(); tick();
    chk("dbl_ready_count", 32'(ready_cycles - r0), 32'h1);
    chk("dbl_fill_count", 32'(req_cycles - q0), 32'h1);
    chk("dbl_resp_count", 32'(resp_cycles - p0), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
